// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register offsets, FSM
// encoding and the VECTOR register formatting helper.
package irq_controller_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_ACK    = 2'd2;
  localparam logic [1:0] REG_VECTOR = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_ACK = 2'd2
  } irq_state_e;

  localparam int VEC_VALID_BIT = 7;

  // VECTOR reads as the valid flag plus the winning source id, or all zeros.
  function automatic logic [7:0] make_vector(input logic valid, input logic [2:0] id);
    logic [7:0] v;
    v = 8'h00;
    if (valid) begin
      v[VEC_VALID_BIT] = 1'b1;
      v[2:0]           = id;
    end else begin
      v = 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
module irq_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] id,
  output logic       valid
);

  // Fixed-priority resolve of the enabled pending requests
  always_comb begin
    id    = 3'd0;
    valid = 1'b1;
    casez (req)
      8'b???????1: id = 3'd0;
      8'b??????10: id = 3'd1;
      8'b?????100: id = 3'd2;
      8'b????1000: id = 3'd3;
      8'b???10000: id = 3'd4;
      8'b??100000: id = 3'd5;
      8'b?1000000: id = 3'd6;
      8'b10000000: id = 3'd7;
      default: begin
        id    = 3'd0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge-detects request lines, latches
// them, masks, resolves priority and pulses the CPU interrupt until acked.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hF0,
  parameter int         NUM_SRC   = 8,
  parameter int         PULSE_LEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [7:0]         uaddr,
  input  logic [7:0]         udata_i,
  output logic [7:0]         udata_o,
  input  logic               rw,
  output logic               interrupt
);

  localparam logic [7:0] SRC_BITS = 8'((1 << NUM_SRC) - 1);

  logic [7:0] src_ext_s;
  logic [7:0] src_q_r;
  logic [7:0] rise_s;
  logic [7:0] pending_r;
  logic [7:0] mask_r;
  logic [7:0] active_s;
  logic [7:0] ack_clr_s;
  logic [7:0] rdata_s;
  logic [7:0] vector_s;
  logic [2:0] enc_id_s;
  logic       enc_valid_s;
  logic       sel_s;
  logic       wr_s;
  logic       mask_wr_s;
  logic       ack_wr_s;

  irq_state_e state_r;
  irq_state_e next_state_s;
  logic [3:0] count_r;
  logic [3:0] count_next_s;
  logic       interrupt_r;
  logic       interrupt_next_s;

  // Widen the request lines to the 8-bit register width; unused bits stay 0
  always_comb begin
    src_ext_s              = 8'h00;
    src_ext_s[NUM_SRC-1:0] = irq_src;
  end

  assign rise_s    = src_ext_s & ~src_q_r;
  assign sel_s     = (uaddr[7:2] == BASE_ADDR[7:2]);
  assign wr_s      = sel_s & rw;
  assign mask_wr_s = wr_s & (uaddr[1:0] == REG_MASK);
  assign ack_wr_s  = wr_s & (uaddr[1:0] == REG_ACK);
  assign active_s  = pending_r & mask_r;

  // ACK write data selects which pending bits to clear
  always_comb begin
    if (ack_wr_s) begin
      ack_clr_s = udata_i;
    end else begin
      ack_clr_s = 8'h00;
    end
  end

  irq_prio_enc u_prio_enc (
    .req   (active_s),
    .id    (enc_id_s),
    .valid (enc_valid_s)
  );

  assign vector_s = make_vector(enc_valid_s, enc_id_s);

  // Edge history, pending latch and mask register; a new rise beats an ACK clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      src_q_r   <= 8'h00;
      pending_r <= 8'h00;
      mask_r    <= 8'h00;
    end else begin
      src_q_r   <= src_ext_s;
      pending_r <= (pending_r & ~ack_clr_s) | rise_s;
      if (mask_wr_s) begin
        mask_r <= udata_i & SRC_BITS;
      end
    end
  end

  // FSM state, pulse counter and registered interrupt output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      count_r     <= 4'd0;
      interrupt_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      count_r     <= count_next_s;
      interrupt_r <= interrupt_next_s;
    end
  end

  // FSM next-state and counter logic
  always_comb begin
    next_state_s = state_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        if (active_s != 8'h00) begin
          next_state_s = PULSE;
          count_next_s = 4'(PULSE_LEN - 1);
        end else begin
          next_state_s = IDLE;
        end
      end
      PULSE: begin
        if (count_r == 4'd0) begin
          next_state_s = WAIT_ACK;
        end else begin
          count_next_s = count_r - 4'd1;
        end
      end
      WAIT_ACK: begin
        if (ack_wr_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WAIT_ACK;
        end
      end
      default: begin
        next_state_s = IDLE;
        count_next_s = 4'd0;
      end
    endcase
  end

  // The interrupt is high exactly while the FSM occupies PULSE
  always_comb begin
    interrupt_next_s = (next_state_s == PULSE);
  end

  assign interrupt = interrupt_r;

  // Register read mux
  always_comb begin
    case (uaddr[1:0])
      REG_STATUS: rdata_s = pending_r;
      REG_MASK:   rdata_s = mask_r;
      REG_ACK:    rdata_s = 8'h00;
      REG_VECTOR: rdata_s = vector_s;
      default:    rdata_s = 8'h00;
    endcase
  end

  assign udata_o = (sel_s && !rw) ? rdata_s : 8'bzzzzzzzz;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src;
  logic [7:0] uaddr;
  logic [7:0] udata_i;
  wire  [7:0] udata_o;
  logic       rw;
  logic       interrupt;

  typedef struct {
    int         kind;   // 0: bus read value, 1: interrupt level, 2: bus released
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t it;
  int   checks   = 0;
  int   failures = 0;

  irq_controller #(
    .BASE_ADDR (8'hF0),
    .NUM_SRC   (8),
    .PULSE_LEN (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .uaddr     (uaddr),
    .udata_i   (udata_i),
    .udata_o   (udata_o),
    .rw        (rw),
    .interrupt (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every queued expectation refers to the output presented this cycle
  always @(negedge clk) begin
    while (q.size() > 0) begin
      it = q.pop_front();
      checks++;
      case (it.kind)
        0: if (udata_o !== it.exp) begin
             failures++;
             $display("FAIL %s: udata_o got %h expected %h", it.name, udata_o, it.exp);
           end
        1: if (interrupt !== it.exp[0]) begin
             failures++;
             $display("FAIL %s: interrupt got %b expected %b", it.name, interrupt, it.exp[0]);
           end
        default: if (!(udata_o === 8'hzz || udata_o === 8'h00)) begin
             failures++;
             $display("FAIL %s: udata_o got %h expected released bus (z)", it.name, udata_o);
           end
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    uaddr   = a;
    udata_i = d;
    rw      = 1'b1;
    tick();
    rw      = 1'b0;
    udata_i = 8'h00;
  endtask

  task automatic exp_rd(input logic [7:0] a, input logic [7:0] e, input string n);
    uaddr = a;
    rw    = 1'b0;
    q.push_back('{kind: 0, exp: e, name: n});
  endtask

  task automatic exp_irq(input logic e, input string n);
    q.push_back('{kind: 1, exp: {7'b0000000, e}, name: n});
  endtask

  task automatic exp_z(input string n);
    q.push_back('{kind: 2, exp: 8'h00, name: n});
  endtask

  initial begin
    reset   = 1'b0;
    irq_src = 8'h00;
    uaddr   = 8'h00;
    udata_i = 8'h00;
    rw      = 1'b0;
    #22;
    reset = 1'b1;

    // 1: reset state
    tick(); exp_irq(1'b0, "rst_irq"); exp_rd(8'hF0, 8'h00, "rst_status"); settle();
    tick(); exp_rd(8'hF1, 8'h00, "rst_mask"); settle();
    tick(); uaddr = 8'h00; exp_z("rst_bus_z"); settle();

    // 2: single masked-in source, two-cycle pulse
    wr(8'hF1, 8'h04);
    irq_src = 8'h04; exp_irq(1'b0, "s2_pre"); settle();
    tick(); irq_src = 8'h00; exp_irq(1'b0, "s2_latency"); exp_rd(8'hF0, 8'h04, "s2_status"); settle();
    tick(); exp_irq(1'b1, "s2_high0"); exp_rd(8'hF3, 8'h82, "s2_vector"); settle();
    tick(); exp_irq(1'b1, "s2_high1"); settle();
    tick(); exp_irq(1'b0, "s2_low"); settle();
    tick(); exp_irq(1'b0, "s2_wait"); exp_rd(8'hF0, 8'h04, "s2_still_pending"); settle();

    // 3: acknowledge, no re-fire
    wr(8'hF2, 8'h04);
    exp_irq(1'b0, "s3_ack_irq"); exp_rd(8'hF0, 8'h00, "s3_status"); settle();
    tick(); exp_irq(1'b0, "s3_idle1"); exp_rd(8'hF2, 8'h00, "s3_ack_reads0"); settle();
    tick(); exp_irq(1'b0, "s3_idle2"); settle();

    // 4: simultaneous sources, priority, re-fire after partial ack
    wr(8'hF1, 8'hFF);
    irq_src = 8'h22; settle();
    tick(); irq_src = 8'h00; settle();
    tick(); exp_irq(1'b1, "s4_high0"); exp_rd(8'hF3, 8'h81, "s4_vector_src1"); settle();
    tick(); exp_irq(1'b1, "s4_high1"); settle();
    tick(); exp_irq(1'b0, "s4_wait"); exp_rd(8'hF0, 8'h22, "s4_status"); settle();
    wr(8'hF2, 8'h02);
    exp_irq(1'b0, "s4_ack_idle"); exp_rd(8'hF3, 8'h85, "s4_vector_src5"); settle();
    tick(); exp_irq(1'b1, "s4_refire0"); settle();
    tick(); exp_irq(1'b1, "s4_refire1"); settle();
    tick(); exp_irq(1'b0, "s4_refire_end"); settle();
    wr(8'hF2, 8'h20);
    tick(); exp_irq(1'b0, "s4_done"); exp_rd(8'hF0, 8'h00, "s4_cleared"); settle();

    // 5: masked source latches but does not interrupt until unmasked
    wr(8'hF1, 8'h00);
    irq_src = 8'h08; settle();
    tick(); irq_src = 8'h00; exp_irq(1'b0, "s5_masked0"); exp_rd(8'hF0, 8'h08, "s5_status"); settle();
    tick(); exp_irq(1'b0, "s5_masked1"); exp_rd(8'hF3, 8'h00, "s5_vector_none"); settle();
    tick(); exp_irq(1'b0, "s5_masked2"); settle();
    wr(8'hF1, 8'h08);
    exp_irq(1'b0, "s5_unmask_lat"); settle();
    tick(); exp_irq(1'b1, "s5_high0"); settle();
    tick(); exp_irq(1'b1, "s5_high1"); settle();
    tick(); exp_irq(1'b0, "s5_low"); settle();
    wr(8'hF2, 8'h08);

    // Read-only registers, out-of-window decode, bus released during writes
    wr(8'hF0, 8'hFF); exp_rd(8'hF0, 8'h00, "status_ro"); settle();
    wr(8'hF3, 8'hFF); exp_rd(8'hF3, 8'h00, "vector_ro"); settle();
    wr(8'hF1, 8'hA5);
    wr(8'hE1, 8'h5A); exp_rd(8'hF1, 8'hA5, "oow_write_ignored"); settle();
    tick(); uaddr = 8'hE1; exp_z("oow_read_z"); settle();
    uaddr = 8'hF1; udata_i = 8'hA5; rw = 1'b1; exp_z("write_cycle_z"); settle();
    tick(); rw = 1'b0;
    wr(8'hF1, 8'h00);

    // 6a: held level sets pending only once
    irq_src = 8'h01; settle();
    tick(); exp_rd(8'hF0, 8'h01, "s6_level_set"); settle();
    wr(8'hF2, 8'h01);
    for (int i = 0; i < 7; i++) begin
      exp_rd(8'hF0, 8'h00, "s6_level_once"); settle();
      tick();
    end
    irq_src = 8'h00;

    // 6b: asynchronous reset in the middle of a pulse
    wr(8'hF1, 8'h01);
    irq_src = 8'h01; settle();
    tick(); irq_src = 8'h00; settle();
    tick(); exp_irq(1'b1, "s6_pulse_high"); settle();
    tick();
    reset = 1'b0;
    #1;
    exp_irq(1'b0, "s6_async_drop"); settle();
    #1;
    reset = 1'b1;
    tick(); exp_irq(1'b0, "s6_post_irq"); exp_rd(8'hF0, 8'h00, "s6_status_lost"); settle();
    tick(); exp_rd(8'hF1, 8'h00, "s6_mask_lost"); settle();

    tick();
    settle();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the CPU user-memory bus, directly upstream of the CPU `interrupt` input.
- Collects up to 8 external request lines, edge-detects and latches them, applies a software mask, and resolves a fixed priority.
- Drives a timed pulse on the CPU interrupt line, then holds off until software acknowledges through a bus register.

Parameters:
- BASE_ADDR, 8'hF0, user-memory address of register 0; the block decodes BASE_ADDR..BASE_ADDR+3.
- NUM_SRC, 8, number of request lines, 1..8; unused bits read 0.
- PULSE_LEN, 2, cycles the interrupt output stays high per request, 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset.
- irq_src  input  NUM_SRC  raw request lines, synchronous to clk, rising-edge triggered.
- uaddr  input  8  CPU usermem_address.
- udata_i  input  8  CPU usermem_data_out (write data).
- udata_o  output  8  read data to CPU usermem_data_in; 8'bz when not selected or rw=1.
- rw  input  1  1 = write, 0 = read.
- interrupt  output  1  to CPU interrupt input.

Behaviour:
- Reset (reset=0, asynchronous): pending=0, mask=0, src_q=0, state=IDLE, pulse count=0, interrupt=0. udata_o follows the combinational rule below.
- Edge detect: src_q <= irq_src each cycle. rise = irq_src & ~src_q.
  - A rise sets the matching pending bit on the next clk.
  - A level held high produces exactly one set.
- Register map, sel = (uaddr[7:2]==BASE_ADDR[7:2]):
  - +0 STATUS: read-only; returns pending.
  - +1 MASK: read/write; 1 = enabled.
  - +2 ACK: write-1-to-clear pending bits; also ends WAIT_ACK. Reads 0.
  - +3 VECTOR: read-only. Value is {1'b1,4'b0,id[2:0]} when (pending & mask) != 0, else 8'h00.
    - id is the lowest set bit index; bit 0 has the highest priority.
- Writes: take effect on the clk rising edge where sel & rw=1.
- Reads: combinational. udata_o = register when sel & rw=0, else 8'bz.
- Same-cycle ACK clear and new rise on the same bit: the set wins and the bit stays pending.
- Masking: MASK affects only interrupt generation and VECTOR. Masked sources still latch into pending.
- FSM (state register, 2 bits):
  - IDLE: if (pending & mask) != 0, go to PULSE next cycle with count=PULSE_LEN-1; interrupt=1 from that cycle.
  - PULSE: interrupt=1. Decrement count; at count==0 go to WAIT_ACK. Total high time is exactly PULSE_LEN cycles.
  - WAIT_ACK: interrupt=0. Any ACK write (even data 0) goes to IDLE next cycle.
  - IDLE re-evaluates, so still-pending enabled sources re-fire one cycle after leaving WAIT_ACK.
- interrupt is a registered output; no combinational path from irq_src.
- Reset asserted mid-PULSE: interrupt drops immediately (asynchronously) and all pending state is lost.
- Writes to STATUS/VECTOR are ignored. Addresses outside the 4-register window are ignored and the bus stays z.

Decomposition:
- Shared package holds:
  - register offsets: REG_STATUS=0, REG_MASK=1, REG_ACK=2, REG_VECTOR=3
  - FSM state encoding: IDLE=2'd0, PULSE=2'd1, WAIT_ACK=2'd2
  - VECTOR valid-bit position (7)
- One natural sub-module: irq_prio_enc, a combinational 8-bit lowest-set-bit encoder giving id[2:0] and a valid flag.

Test Plan:
1. Reset, then poll the outputs → interrupt=0; read +0/+1 return 8'h00; udata_o=z at uaddr 8'h00.
2. MASK=8'h04; pulse irq_src[2] high for 1 cycle → STATUS=8'h04; interrupt high exactly 2 cycles starting 2 cycles after the edge; VECTOR=8'h82.
3. Same setup; write ACK=8'h04 → pending=0, FSM back to IDLE; no further pulse.
4. MASK=8'hFF; raise src 5 and src 1 in the same cycle → VECTOR=8'h81. Write ACK=8'h02 → src 5 re-fires, VECTOR=8'h85.
5. MASK=8'h00; raise src 3 → STATUS=8'h08, interrupt stays 0, VECTOR=8'h00. Then write MASK=8'h08 → pulse follows.
6. During PULSE, assert reset=0 → interrupt drops with no clock edge; STATUS=0 after release. Also hold irq_src[0] high 10 cycles → only one pending set.
